pll_reconfig_ctrl: RTL and testbench
====================================

Name: pll_reconfig_ctrl

Overview:
- Sequencer for a PLL's dynamic-divider interface, the driving counterpart of the lock checker used in PLL benches.
- Accepts a new output-divider/duty request and drives the `dyn_odiv`/`dyn_duty` values.
- Pulses `pll_rst`, waits for a stable `pll_lock` with a timeout, then monitors the lock for loss.
- Sits between the register/control logic and a PLL IP instance; all logic is on `clk_tb`.

Parameters:
- DIV_W, 10, width of divider/duty fields.
- DEF_ODIV, 100, `dyn_odiv` value after reset.
- DEF_DUTY, 100, `dyn_duty` value after reset.
- RST_CYCLES, 16, cycles `pll_rst` is held high per reset sequence (>=1).
- LOCK_STABLE, 64, consecutive synced-lock-high cycles required to declare lock (>=1).
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before failure (> LOCK_STABLE).

Ports:
- clk_tb, input, 1, control clock.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_req, input, 1, request level; held by requester until cfg_ack.
- cfg_odiv, input, DIV_W, requested output divider; sampled when cfg_ack is high.
- cfg_duty, input, DIV_W, requested duty value; sampled when cfg_ack is high.
- cfg_ack, output, 1, one-cycle acceptance pulse.
- cfg_err, output, 1, one-cycle pulse coincident with cfg_ack when the request is rejected.
- pll_lock, input, 1, PLL lock; asynchronous to clk_tb.
- pll_rst, output, 1, PLL reset, active high.
- dyn_odiv, output, DIV_W, divider value driven to the PLL.
- dyn_duty, output, DIV_W, duty value driven to the PLL.
- busy, output, 1, high while in RESET or WAIT_LOCK.
- locked, output, 1, high only in RUN.
- err_timeout, output, 1, sticky lock-timeout flag.
- err_unlock, output, 1, sticky loss-of-lock flag.
- unlock_cnt, output, 3, saturating count of lock losses in RUN.

Behaviour:
- Reset values:
  - `dyn_odiv=DEF_ODIV`, `dyn_duty=DEF_DUTY`.
  - `pll_rst=1`.
  - `cfg_ack`, `cfg_err`, `locked`, `err_timeout`, `err_unlock` = 0; `unlock_cnt=0`; `busy=1`.
  - State = RESET, counters cleared.
- Lock synchronisation:
  - `pll_lock` passes through a 2-flop synchroniser to give `lock_s`.
  - All decisions use `lock_s`, so lock input to effect latency is 2 cycles plus the FSM edge.
- FSM states: RESET, WAIT_LOCK, RUN, FAIL.
- RESET:
  - `pll_rst=1` for exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK with `pll_rst=0` on the same edge.
  - Lock timer and stable counter cleared.
- WAIT_LOCK:
  - Lock timer increments every cycle.
  - Stable counter increments while `lock_s=1` and clears when `lock_s=0`.
  - When the stable counter reaches LOCK_STABLE: go to RUN, `locked=1` from the next cycle.
  - Else, when the timer reaches LOCK_TIMEOUT: go to FAIL and set `err_timeout=1`.
  - If both occur on the same cycle, lock wins.
- RUN:
  - A `lock_s` falling edge sets `err_unlock=1` and increments `unlock_cnt`, saturating at 7.
  - The same edge drops `locked` and starts an automatic re-lock via RESET.
- FAIL:
  - `pll_rst=0`, `locked=0`.
  - Stays in FAIL until an accepted cfg request.
- Request handshake:
  - `cfg_req` is evaluated only in RUN or FAIL. In RESET/WAIT_LOCK it is ignored and the requester keeps holding it.
  - On acceptance, `cfg_ack=1` for one cycle.
  - Valid request (`cfg_odiv!=0`, `cfg_duty!=0`, `cfg_duty<=2*cfg_odiv`):
    - `dyn_odiv`/`dyn_duty` load the request on the ack edge.
    - `err_timeout`, `err_unlock` and `unlock_cnt` clear.
    - `locked` drops; FSM goes to RESET.
  - Invalid request:
    - `cfg_err=1` with `cfg_ack`; outputs and state are unchanged.
  - Requester must drop `cfg_req` the cycle after `cfg_ack`. A request still high 2 cycles after ack is treated as a new request.
- Precedence in RUN: a lock loss on the same cycle as `cfg_req` takes priority. The request is not acked and is re-evaluated once RUN or FAIL is reached again.
- `dyn_odiv`/`dyn_duty` are registered and stable outside the ack edge.
- Asserting `rst_n` mid-sequence returns all outputs to reset values immediately (asynchronously).
- Counter widths: `$clog2` of the respective parameter plus 1; no wrap in normal operation.

Test Plan:
- Power-up:
  - Stimulus: release `rst_n`, `pll_lock` goes 1 at cycle 40.
  - Response: `pll_rst` high for cycles 0-15; `locked` rises exactly 2+64 cycles after `pll_lock` plus FSM edge; `dyn_odiv=100`, `dyn_duty=100`.
- Valid reconfig:
  - Stimulus: in RUN, `cfg_req` with `odiv=200`, `duty=200`.
  - Response: `cfg_ack` 1 cycle, `cfg_err=0`; `dyn_odiv=200` and `dyn_duty=200` on the ack edge; `locked=0`; `pll_rst` high for 16 cycles; `locked` returns after stable lock.
- Invalid reconfig:
  - Stimulus: `odiv=0` (or `odiv=10`, `duty=30`).
  - Response: `cfg_ack` and `cfg_err` pulse together; `dyn_*` unchanged; `locked` stays 1.
- Timeout:
  - Stimulus: `pll_lock` held 0.
  - Response: FAIL after 16+4096 cycles; `err_timeout=1`; `busy=0`.
  - Then a valid `cfg_req` clears `err_timeout` and restarts RESET.
- Lock glitch:
  - Stimulus: in RUN, `pll_lock` low for 3 cycles, repeated 9 times.
  - Response: each glitch sets `err_unlock` and triggers a re-lock; `unlock_cnt` saturates at 7.
- Lock chatter plus mid-sequence reset:
  - Stimulus: `lock` toggles every 30 cycles in WAIT_LOCK.
  - Response: never declares lock, times out.
  - Stimulus: `rst_n` pulse during WAIT_LOCK.
  - Response: `pll_rst=1` and all flags are 0 immediately.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   Sequences a PLL's dynamic output divider / duty interface. A request is
//   accepted only when the PLL is settled (RUN) or has given up (FAIL). A valid
//   request loads dyn_odiv/dyn_duty, pulses pll_rst for RST_CYCLES cycles, then
//   waits for LOCK_STABLE consecutive cycles of synchronised lock, giving up
//   after LOCK_TIMEOUT cycles. In RUN, any loss of lock is counted and triggers
//   an automatic re-lock.
//
// Ports
//   clk_tb       control clock
//   rst_n        asynchronous active-low reset
//   cfg_req      request level, held by the requester until cfg_ack
//   cfg_odiv     requested divider
//   cfg_duty     requested duty value
//   cfg_ack      one-cycle acceptance pulse
//   cfg_err      one-cycle pulse with cfg_ack when the request is rejected
//   pll_lock     PLL lock, asynchronous to clk_tb
//   pll_rst      PLL reset, active high
//   dyn_odiv     divider value driven to the PLL
//   dyn_duty     duty value driven to the PLL
//   busy         high in RESET or WAIT_LOCK
//   locked       high only in RUN
//   err_timeout  sticky lock-timeout flag
//   err_unlock   sticky loss-of-lock flag
//   unlock_cnt   saturating count of lock losses seen in RUN
module pll_reconfig_ctrl #(
  parameter int DIV_W        = 10,
  parameter int DEF_ODIV     = 100,
  parameter int DEF_DUTY     = 100,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_odiv,
  input  logic [DIV_W-1:0] cfg_duty,
  output logic             cfg_ack,
  output logic             cfg_err,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic [DIV_W-1:0] dyn_odiv,
  output logic [DIV_W-1:0] dyn_duty,
  output logic             busy,
  output logic             locked,
  output logic             err_timeout,
  output logic             err_unlock,
  output logic [2:0]       unlock_cnt
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  localparam int RC_W = $clog2(RST_CYCLES) + 1;
  localparam int ST_W = $clog2(LOCK_STABLE) + 1;
  localparam int TM_W = $clog2(LOCK_TIMEOUT) + 1;

  // Terminal values are compared against the current count, so the transition
  // happens on the edge that completes the last counted cycle.
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(LOCK_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic             lock_meta_q, lock_s_q, lock_prev_q;
  logic             cfg_ack_q, cfg_ack_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0] odiv_q, odiv_d;
  logic [DIV_W-1:0] duty_q, duty_d;
  logic             err_to_q, err_to_d;
  logic             err_ul_q, err_ul_d;
  logic [2:0]       ucnt_q, ucnt_d;

  logic             unlock_ev;
  logic             req_take;
  logic             req_valid;

  // Falling edge of the synchronised lock while running.
  assign unlock_ev = (state_q == ST_RUN) && lock_prev_q && !lock_s_q;

  // A lock loss wins over a simultaneous request; the requester keeps holding
  // cfg_req. The cycle right after an ack is ignored so a requester dropping
  // cfg_req one cycle late is not taken twice.
  assign req_take  = ((state_q == ST_RUN) || (state_q == ST_FAIL)) &&
                     cfg_req && !cfg_ack_q && !unlock_ev;

  assign req_valid = (cfg_odiv != '0) && (cfg_duty != '0) &&
                     ({1'b0, cfg_duty} <= {cfg_odiv, 1'b0});

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stable_d  = stable_q;
    timer_d   = timer_q;
    cfg_ack_d = 1'b0;
    cfg_err_d = 1'b0;
    odiv_d    = odiv_q;
    duty_d    = duty_q;
    err_to_d  = err_to_q;
    err_ul_d  = err_ul_q;
    ucnt_d    = ucnt_q;

    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d   = ST_WAIT;
          rst_cnt_d = '0;
          stable_d  = '0;
          timer_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_WAIT: begin
        timer_d  = timer_q + TM_W'(1);
        stable_d = lock_s_q ? stable_q + ST_W'(1) : '0;
        if (lock_s_q && (stable_q == ST_LAST)) begin
          state_d = ST_RUN;
        end else if (timer_q == TM_LAST) begin
          state_d  = ST_FAIL;
          err_to_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (unlock_ev) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          err_ul_d  = 1'b1;
          if (ucnt_q != 3'd7) begin
            ucnt_d = ucnt_q + 3'd1;
          end
        end
      end
      default: begin
      end
    endcase

    if (req_take) begin
      cfg_ack_d = 1'b1;
      if (req_valid) begin
        odiv_d    = cfg_odiv;
        duty_d    = cfg_duty;
        err_to_d  = 1'b0;
        err_ul_d  = 1'b0;
        ucnt_d    = 3'd0;
        state_d   = ST_RESET;
        rst_cnt_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      stable_q    <= '0;
      timer_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lock_prev_q <= 1'b0;
      cfg_ack_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      odiv_q      <= DIV_W'(DEF_ODIV);
      duty_q      <= DIV_W'(DEF_DUTY);
      err_to_q    <= 1'b0;
      err_ul_q    <= 1'b0;
      ucnt_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stable_q    <= stable_d;
      timer_q     <= timer_d;
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      lock_prev_q <= lock_s_q;
      cfg_ack_q   <= cfg_ack_d;
      cfg_err_q   <= cfg_err_d;
      odiv_q      <= odiv_d;
      duty_q      <= duty_d;
      err_to_q    <= err_to_d;
      err_ul_q    <= err_ul_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign cfg_ack     = cfg_ack_q;
  assign cfg_err     = cfg_err_q;
  assign pll_rst     = (state_q == ST_RESET);
  assign busy        = (state_q == ST_RESET) || (state_q == ST_WAIT);
  assign locked      = (state_q == ST_RUN);
  assign dyn_odiv    = odiv_q;
  assign dyn_duty    = duty_q;
  assign err_timeout = err_to_q;
  assign err_unlock  = err_ul_q;
  assign unlock_cnt  = ucnt_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: directed sequences and a request table, with a
// cycle-level reference model checking every output on every falling clock
// edge, followed by a randomized phase.
module tb_pll_reconfig_ctrl;

  localparam int DIV_W        = 10;
  localparam int DEF_ODIV     = 100;
  localparam int DEF_DUTY     = 100;
  localparam int RST_CYCLES   = 16;
  localparam int LOCK_STABLE  = 64;
  localparam int LOCK_TIMEOUT = 4096;

  logic             clk_tb;
  logic             rst_n;
  logic             cfg_req;
  logic [DIV_W-1:0] cfg_odiv;
  logic [DIV_W-1:0] cfg_duty;
  logic             cfg_ack;
  logic             cfg_err;
  logic             pll_lock;
  logic             pll_rst;
  logic [DIV_W-1:0] dyn_odiv;
  logic [DIV_W-1:0] dyn_duty;
  logic             busy;
  logic             locked;
  logic             err_timeout;
  logic             err_unlock;
  logic [2:0]       unlock_cnt;

  pll_reconfig_ctrl #(
    .DIV_W(DIV_W), .DEF_ODIV(DEF_ODIV), .DEF_DUTY(DEF_DUTY),
    .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_odiv(cfg_odiv),
    .cfg_duty(cfg_duty), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty), .busy(busy),
    .locked(locked), .err_timeout(err_timeout), .err_unlock(err_unlock),
    .unlock_cnt(unlock_cnt)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  int n_cmp = 0;
  int n_bad = 0;
  int model_prints = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within its cycle budget", nm);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {PH_RESET, PH_WAIT, PH_RUN, PH_FAIL} ph_t;

  ph_t m_ph;
  ph_t m_pre;
  bit  m_fell, m_take;
  int  m_elapsed, m_run;
  bit  m_meta, m_ls, m_ls_old;
  bit  m_ack, m_err, m_to, m_ul;
  int  m_cnt, m_odiv, m_duty;

  function automatic bit req_ok(input int o, input int d);
    return (o != 0) && (d != 0) && (d <= 2 * o);
  endfunction

  always @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PH_RESET; m_elapsed = 0; m_run = 0;
      m_meta = 0; m_ls = 0; m_ls_old = 0;
      m_ack = 0; m_err = 0; m_to = 0; m_ul = 0; m_cnt = 0;
      m_odiv = DEF_ODIV; m_duty = DEF_DUTY;
    end else begin
      m_pre  = m_ph;
      m_fell = (m_pre == PH_RUN) && m_ls_old && !m_ls;
      m_take = ((m_pre == PH_RUN) || (m_pre == PH_FAIL)) && cfg_req && !m_ack && !m_fell;
      case (m_pre)
        PH_RESET: begin
          m_elapsed++;
          if (m_elapsed == RST_CYCLES) begin
            m_ph = PH_WAIT; m_elapsed = 0; m_run = 0;
          end
        end
        PH_WAIT: begin
          m_elapsed++;
          m_run = m_ls ? m_run + 1 : 0;
          if (m_run == LOCK_STABLE) m_ph = PH_RUN;
          else if (m_elapsed == LOCK_TIMEOUT) begin
            m_ph = PH_FAIL; m_to = 1;
          end
        end
        PH_RUN: begin
          if (m_fell) begin
            m_ul = 1; m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            m_ph = PH_RESET; m_elapsed = 0;
          end
        end
        default: ;
      endcase
      m_ack = m_take;
      m_err = m_take && !req_ok(int'(cfg_odiv), int'(cfg_duty));
      if (m_take && req_ok(int'(cfg_odiv), int'(cfg_duty))) begin
        m_odiv = int'(cfg_odiv); m_duty = int'(cfg_duty);
        m_to = 0; m_ul = 0; m_cnt = 0;
        m_ph = PH_RESET; m_elapsed = 0;
      end
      m_ls_old = m_ls; m_ls = m_meta; m_meta = pll_lock;
    end
  end

  logic [2*DIV_W+9:0] act_v, exp_v;

  always @(negedge clk_tb) begin
    act_v = {pll_rst, busy, locked, cfg_ack, cfg_err, err_timeout, err_unlock,
             unlock_cnt, dyn_odiv, dyn_duty};
    exp_v = {m_ph == PH_RESET, (m_ph == PH_RESET) || (m_ph == PH_WAIT), m_ph == PH_RUN,
             m_ack, m_err, m_to, m_ul, 3'(m_cnt), DIV_W'(m_odiv), DIV_W'(m_duty)};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      if (model_prints < 20) begin
        model_prints++;
        $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic send_req(input int o, input int d, input int bound, output bit got);
    cfg_odiv = DIV_W'(o);
    cfg_duty = DIV_W'(d);
    cfg_req  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk_tb);
      if (cfg_ack) begin
        got = 1'b1;
        break;
      end
    end
    cfg_req = 1'b0;
    if (!got) bound_fail("req_ack_wait");
  endtask

  task automatic wait_locked(input int bound);
    bit ok;
    ok = locked;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk_tb);
      ok = locked;
    end
    if (!ok) bound_fail("wait_locked");
  endtask

  task automatic count_rst_high(input string nm);
    int hi;
    hi = 0;
    for (int k = 0; k < 40 && pll_rst; k++) begin
      hi++;
      @(negedge clk_tb);
    end
    check(nm, hi, RST_CYCLES);
  endtask

  typedef struct {
    int odiv;
    int duty;
    bit exp_err;
  } vec_t;

  vec_t tbl[10];
  bit   chat_on;
  bit   got;
  int   exp_odiv, exp_duty;
  int   first_lock, rst_hi, n;
  bit   seen_lock;
  int   glitch_left;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{200, 200, 1'b0};
    tbl[1] = '{0, 50, 1'b1};
    tbl[2] = '{10, 30, 1'b1};
    tbl[3] = '{10, 20, 1'b0};
    tbl[4] = '{37, 0, 1'b1};
    tbl[5] = '{1023, 1023, 1'b0};
    tbl[6] = '{1, 2, 1'b0};
    tbl[7] = '{1, 3, 1'b1};
    tbl[8] = '{512, 1023, 1'b0};
    tbl[9] = '{3, 7, 1'b1};

    rst_n = 1'b0; cfg_req = 1'b0; cfg_odiv = '0; cfg_duty = '0; pll_lock = 1'b0;
    chat_on = 1'b0; glitch_left = 0;

    // reset state
    repeat (3) @(negedge clk_tb);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_busy", busy, 1);
    check("rst_locked", locked, 0);
    check("rst_ack_err", {cfg_ack, cfg_err}, 0);
    check("rst_flags", {err_timeout, err_unlock, unlock_cnt}, 0);
    check("rst_dyn_odiv", dyn_odiv, DEF_ODIV);
    check("rst_dyn_duty", dyn_duty, DEF_DUTY);

    // power-up: pll_lock rises at cycle 40
    rst_n = 1'b1;
    rst_hi = 0; first_lock = -1;
    for (int c = 0; c <= 120; c++) begin
      if (pll_rst && first_lock < 0) rst_hi++;
      if (locked && first_lock < 0) first_lock = c;
      if (c == 40) pll_lock = 1'b1;
      @(negedge clk_tb);
    end
    check("pwr_rst_cycles", rst_hi, RST_CYCLES);
    check("pwr_lock_cycle", first_lock, 40 + 2 + LOCK_STABLE);
    check("pwr_dyn", {dyn_odiv, dyn_duty}, {10'd100, 10'd100});

    // request table applied in RUN
    exp_odiv = DEF_ODIV; exp_duty = DEF_DUTY;
    foreach (tbl[i]) begin
      wait_locked(300);
      send_req(tbl[i].odiv, tbl[i].duty, 10, got);
      if (got) begin
        if (!tbl[i].exp_err) begin
          exp_odiv = tbl[i].odiv; exp_duty = tbl[i].duty;
        end
        check("tbl_err", cfg_err, tbl[i].exp_err);
        check("tbl_dyn_odiv", dyn_odiv, exp_odiv);
        check("tbl_dyn_duty", dyn_duty, exp_duty);
        check("tbl_locked", locked, tbl[i].exp_err);
        if (!tbl[i].exp_err) begin
          count_rst_high("tbl_rst_cycles");
        end else begin
          @(negedge clk_tb);
          check("tbl_ack_one_cycle", cfg_ack, 0);
        end
      end
    end
    wait_locked(300);

    // lock loss and request on the same cycle: loss wins, request acked later
    @(negedge clk_tb);
    pll_lock = 1'b0;
    repeat (2) @(negedge clk_tb);
    cfg_odiv = DIV_W'(64); cfg_duty = DIV_W'(100); cfg_req = 1'b1;
    @(negedge clk_tb);
    check("prec_no_ack", cfg_ack, 0);
    check("prec_locked", locked, 0);
    check("prec_unlock", err_unlock, 1);
    pll_lock = 1'b1;
    send_req(64, 100, 400, got);
    if (got) begin
      check("prec_dyn", {dyn_odiv, dyn_duty}, {10'd64, 10'd100});
      check("prec_flags_clear", {err_unlock, unlock_cnt}, 0);
    end
    wait_locked(300);

    // nine 3-cycle lock glitches: unlock_cnt saturates at 7
    for (int g = 0; g < 9; g++) begin
      wait_locked(300);
      pll_lock = 1'b0;
      repeat (3) @(negedge clk_tb);
      check("glitch_locked_drop", locked, 0);
      pll_lock = 1'b1;
      wait_locked(300);
      check("glitch_cnt", unlock_cnt, (g + 1 < 7) ? g + 1 : 7);
      check("glitch_flag", err_unlock, 1);
    end

    // timeout with lock held low
    pll_lock = 1'b0;
    for (int k = 0; k < 10 && !pll_rst; k++) @(negedge clk_tb);
    for (int k = 0; k < 40 && pll_rst; k++) @(negedge clk_tb);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk_tb);
      n++;
    end
    check("to_wait_cycles", n, LOCK_TIMEOUT);
    check("to_flag", err_timeout, 1);
    check("to_outputs", {busy, locked, pll_rst}, 0);

    // invalid request in FAIL: rejected, stays in FAIL
    @(negedge clk_tb);
    send_req(0, 5, 10, got);
    if (got) begin
      check("fail_inv_err", cfg_err, 1);
      check("fail_inv_flag", err_timeout, 1);
      check("fail_inv_dyn", dyn_odiv, 64);
    end
    @(negedge clk_tb);
    check("fail_inv_busy", busy, 0);

    // valid request in FAIL with lock chattering every 30 cycles
    chat_on = 1'b1;
    fork
      begin
        while (chat_on) begin
          repeat (30) @(negedge clk_tb);
          pll_lock = ~pll_lock;
        end
      end
    join_none
    send_req(100, 50, 10, got);
    if (got) begin
      check("chat_clear_to", err_timeout, 0);
      check("chat_rst", pll_rst, 1);
    end
    seen_lock = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk_tb);
      seen_lock |= locked;
      n++;
    end
    check("chat_never_locked", seen_lock, 0);
    check("chat_timeout", {busy, err_timeout}, 2'b01);
    chat_on = 1'b0;
    repeat (40) @(negedge clk_tb);
    pll_lock = 1'b0;

    // asynchronous reset during WAIT_LOCK
    send_req(80, 80, 10, got);
    for (int k = 0; k < 40 && pll_rst; k++) @(negedge clk_tb);
    repeat (10) @(negedge clk_tb);
    check("mid_in_wait", {pll_rst, busy}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_pll_rst", pll_rst, 1);
    check("mid_flags", {locked, cfg_ack, cfg_err, err_timeout, err_unlock, unlock_cnt}, 0);
    check("mid_dyn", {dyn_odiv, dyn_duty}, {10'd100, 10'd100});
    repeat (2) @(negedge clk_tb);
    rst_n = 1'b1;
    pll_lock = 1'b1;

    // randomized requests and lock glitches, checked by the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_tb);
      if (cfg_req) begin
        if (cfg_ack) cfg_req = 1'b0;
      end else if ($urandom_range(0, 40) == 0) begin
        cfg_odiv = DIV_W'($urandom_range(0, 15));
        cfg_duty = DIV_W'($urandom_range(0, 31));
        cfg_req  = 1'b1;
      end
      if (glitch_left > 0) begin
        glitch_left--;
        pll_lock = (glitch_left == 0);
      end else if ($urandom_range(0, 150) == 0) begin
        glitch_left = $urandom_range(1, 6);
        pll_lock = 1'b0;
      end
    end
    cfg_req = 1'b0;
    repeat (3) @(negedge clk_tb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
